// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the address decoder and its default slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [1:0] SLV_1 = 2'b00;
    localparam logic [1:0] SLV_2 = 2'b01;
    localparam logic [1:0] SLV_3 = 2'b10;
    localparam logic [1:0] SLV_4 = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ERR1 = 2'b01,
        ERR2 = 2'b10
    } dflt_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers active transfers to unmapped addresses with the
// two-cycle AHB ERROR response; outputs depend on state only.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       hclk,
    input  logic       hresetn,
    input  logic       hready,
    input  logic [1:0] htrans,
    input  logic       unmapped,
    output logic       dflt_hreadyout,
    output logic       dflt_hresp
);

    dflt_state_t state;
    dflt_state_t state_next;

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = IDLE;
        dflt_hreadyout = 1'b1;
        dflt_hresp     = HRESP_OKAY;
        case (state)
            IDLE: begin
                if (hready && unmapped && htrans[1]) begin
                    state_next = ERR1;
                end
            end
            ERR1: begin
                dflt_hreadyout = 1'b0;
                dflt_hresp     = HRESP_ERROR;
                state_next     = ERR2;
            end
            ERR2: begin
                // Last error cycle completes the transfer, so a new address
                // phase is accepted here and evaluated exactly as from IDLE.
                dflt_hresp = HRESP_ERROR;
                if (hready && unmapped && htrans[1]) begin
                    state_next = ERR1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/ahb_decoder.sv
// AHB-Lite address decoder: one-hot address-phase selects, registered
// data-phase select for the response mux, and a default slave for holes.
module ahb_decoder
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_1 = 32'h0000_0000,
    parameter logic [31:0] BASE_2 = 32'h1000_0000,
    parameter logic [31:0] BASE_3 = 32'h2000_0000,
    parameter logic [31:0] BASE_4 = 32'h4000_0000,
    parameter logic [31:0] MASK_N = 32'hF000_0000
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hready,
    output logic        hsel_1,
    output logic        hsel_2,
    output logic        hsel_3,
    output logic        hsel_4,
    output logic [1:0]  sel,
    output logic        dflt_active,
    output logic        dflt_hreadyout,
    output logic        dflt_hresp
);

    logic [3:0] match;
    logic [1:0] idx;
    logic       unmapped;

    always_comb begin
        match[0] = ((haddr & MASK_N) == BASE_1);
        match[1] = ((haddr & MASK_N) == BASE_2);
        match[2] = ((haddr & MASK_N) == BASE_3);
        match[3] = ((haddr & MASK_N) == BASE_4);
    end

    // Priority chain keeps the selects one-hot when regions overlap.
    always_comb begin
        hsel_1   = 1'b0;
        hsel_2   = 1'b0;
        hsel_3   = 1'b0;
        hsel_4   = 1'b0;
        idx      = SLV_1;
        unmapped = 1'b0;
        if (match[0]) begin
            hsel_1 = 1'b1;
            idx    = SLV_1;
        end else if (match[1]) begin
            hsel_2 = 1'b1;
            idx    = SLV_2;
        end else if (match[2]) begin
            hsel_3 = 1'b1;
            idx    = SLV_3;
        end else if (match[3]) begin
            hsel_4 = 1'b1;
            idx    = SLV_4;
        end else begin
            unmapped = 1'b1;
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            sel         <= SLV_1;
            dflt_active <= 1'b0;
        end else if (hready) begin
            dflt_active <= unmapped;
            if (!unmapped) begin
                sel <= idx;
            end
        end
    end

    ahb_default_slave u_default_slave (
        .hclk           (hclk),
        .hresetn        (hresetn),
        .hready         (hready),
        .htrans         (htrans),
        .unmapped       (unmapped),
        .dflt_hreadyout (dflt_hreadyout),
        .dflt_hresp     (dflt_hresp)
    );

endmodule
